// File: rtl/branch_redirect_queue.sv
// In-order queue of resolved-branch redirects feeding the barrel-threaded PC stage.
// Optional drop statistics counter is enabled by defining BRQ_DROP_STATS_EN.
module branch_redirect_queue #(
  parameter int XLEN        = 32,
  parameter int NUM_THREADS = 8,
  parameter int TID_W       = 3,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid_i,
  input  logic [TID_W-1:0]         ex_thread_id_i,
  input  logic [XLEN-1:0]          ex_target_i,
  output logic [TID_W-1:0]         br_thread_id_o,
  output logic [XLEN-1:0]          br_pc_o,
  output logic                     branch_fifo_empty_o,
  input  logic                     br_ack_i,
  output logic [NUM_THREADS-1:0]   pending_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TID_W-1:0]       tid_mem [DEPTH];
  logic [XLEN-1:0]        pc_mem  [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [NUM_THREADS-1:0] pending;

  logic [PW-1:0]          count;
  logic                   empty;
  logic                   full_blk;
  logic                   pop;
  logic                   push_req;
  logic                   push;
  logic [TID_W-1:0]       head_tid;
  logic [NUM_THREADS-1:0] pend_clr;
  logic [NUM_THREADS-1:0] pend_set;
  logic [NUM_THREADS-1:0] pending_eff;
  logic [NUM_THREADS-1:0] pending_next;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign head_tid = tid_mem[rd_ptr[AW-1:0]];
  assign pop      = br_ack_i & ~empty;
  // A same-cycle pop frees a slot, so only a queue that stays full blocks the write.
  assign full_blk = (count == PW'(DEPTH)) & ~pop;

  // The pop's pending clear is applied before the push check so a thread can re-enqueue
  // in the very cycle its previous redirect is acknowledged.
  always_comb begin
    pend_clr = '0;
    pend_set = '0;
    if (pop) pend_clr[head_tid] = 1'b1;
    pending_eff = pending & ~pend_clr;
    push_req    = ex_valid_i & ~pending_eff[ex_thread_id_i];
    push        = push_req & ~full_blk;
    if (push) pend_set[ex_thread_id_i] = 1'b1;
    pending_next = pending_eff | pend_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tid_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        tid_mem[wr_ptr[AW-1:0]] <= ex_thread_id_i;
        pc_mem[wr_ptr[AW-1:0]]  <= {ex_target_i[XLEN-1:2], 2'b00};
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      pending <= pending_next;
    end
  end

  assign br_thread_id_o      = head_tid;
  assign br_pc_o             = pc_mem[rd_ptr[AW-1:0]];
  assign branch_fifo_empty_o = empty;
  assign pending_o           = pending;
  assign count_o             = count;

`ifdef BRQ_DROP_STATS_EN
  logic             drop;
  logic [CNT_W-1:0] drop_cnt;

  assign drop = ex_valid_i & ~push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push_req && full_blk))
        else $error("branch_redirect_queue: push while full, redirect dropped");
    end
  end
`endif

endmodule
